// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder.
//   RESP_*        : BRESP/RRESP encodings
//   SIZE_*        : AxSIZE encodings that the responder accepts
//   write_state_t : write-path FSM states
//   read_state_t  : read-path FSM states
//   resp_check    : address/size check that produces the response code
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COMMIT,
      W_RESP
   } write_state_t;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } read_state_t;

   // Range is checked before alignment, so an out-of-range misaligned
   // access reports DECERR rather than SLVERR.
   function automatic logic [1:0] resp_check(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [31:0] depth);
      if ({2'b00, addr[31:2]} >= depth)
         return RESP_DECERR;
      if (size > SIZE_WORD)
         return RESP_SLVERR;
      if ((size == SIZE_HALF) && addr[0])
         return RESP_SLVERR;
      if ((size == SIZE_WORD) && (addr[1:0] != 2'b00))
         return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// DEPTH x 32 storage with one byte-enabled write port and one registered
// read port. Both ports act on the same edge; a read of the word being
// written returns the previous contents.
//   clk   : clock
//   we    : write enable, wstrb selects the bytes written at waddr
//   waddr, wdata, wstrb : write port
//   re    : read enable, rdata loads mem[raddr] on the edge and holds otherwise
//   raddr, rdata        : read port
module axi_sram_mem #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wstrb,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (re)
         rdata <= mem[raddr];
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b])
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder backed by a byte-enabled word SRAM.
// Independent read and write paths, one outstanding transaction each,
// WAIT_CYCLES idle cycles before every address/data ready pulse, and
// OKAY/SLVERR/DECERR responses from the address/size check.
//   clk, m_aresetn          : clock, synchronous active-low reset
//   s_axi_aw* / s_axi_w*    : write address and write data channels
//   s_axi_b*                : write response channel
//   s_axi_ar*               : read address channel
//   s_axi_r*                : read data channel (rdata is 0 on error)
module axi_lite_sram_slave
   import axi_lite_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        m_aresetn,
   input  logic [31:0] s_axi_awaddr,
   input  logic [2:0]  s_axi_awsize,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arsize,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [3:0]  WAIT_C  = 4'(WAIT_CYCLES);
   localparam logic [31:0] DEPTH_C = 32'(DEPTH);

   write_state_t wr_state;
   logic [3:0]   aw_cnt;
   logic [3:0]   w_cnt;
   logic         aw_got;
   logic         w_got;
   logic         aw_hs;
   logic         w_hs;
   logic [31:0]  awaddr_q;
   logic [2:0]   awsize_q;
   logic [31:0]  wdata_q;
   logic [3:0]   wstrb_q;
   logic [1:0]   wr_resp;
   logic         mem_we;

   read_state_t  rd_state;
   logic [3:0]   ar_cnt;
   logic         ar_hs;
   logic [1:0]   rd_resp;
   logic [31:0]  mem_q;

   // Readies are a decode of the wait counters so that WAIT_CYCLES=0 gives
   // a same-cycle ready; they are forced low while reset is held.
   assign s_axi_awready = m_aresetn && (wr_state == W_IDLE) && !aw_got &&
                          s_axi_awvalid && (aw_cnt == WAIT_C);
   assign s_axi_wready  = m_aresetn && (wr_state == W_IDLE) && !w_got &&
                          s_axi_wvalid && (w_cnt == WAIT_C);
   assign s_axi_arready = m_aresetn && (rd_state == R_IDLE) &&
                          s_axi_arvalid && (ar_cnt == WAIT_C);

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   assign wr_resp = resp_check(awaddr_q, awsize_q, DEPTH_C);
   assign rd_resp = resp_check(s_axi_araddr, s_axi_arsize, DEPTH_C);

   // Reset gates the commit so a transaction caught in W_COMMIT is dropped.
   assign mem_we = m_aresetn && (wr_state == W_COMMIT) && (wr_resp == RESP_OKAY);

   // Error responses return zero data instead of whatever the RAM held.
   assign s_axi_rdata = (s_axi_rvalid && (s_axi_rresp == RESP_OKAY)) ? mem_q : 32'h0;

   // ---- write channel capture ----
   always_ff @(posedge clk) begin
      if (aw_hs) begin
         awaddr_q <= s_axi_awaddr;
         awsize_q <= s_axi_awsize;
      end
      if (w_hs) begin
         wdata_q <= s_axi_wdata;
         wstrb_q <= s_axi_wstrb;
      end
   end

   // ---- write FSM ----
   always_ff @(posedge clk) begin
      if (!m_aresetn) begin
         wr_state     <= W_IDLE;
         aw_cnt       <= 4'd0;
         w_cnt        <= 4'd0;
         aw_got       <= 1'b0;
         w_got        <= 1'b0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
      end else begin
         case (wr_state)
            W_IDLE: begin
               // A valid that drops before its ready pulse restarts the count.
               if (aw_hs) begin
                  aw_got <= 1'b1;
                  aw_cnt <= 4'd0;
               end else if (!aw_got && s_axi_awvalid) begin
                  if (aw_cnt != WAIT_C)
                     aw_cnt <= aw_cnt + 4'd1;
               end else begin
                  aw_cnt <= 4'd0;
               end

               if (w_hs) begin
                  w_got <= 1'b1;
                  w_cnt <= 4'd0;
               end else if (!w_got && s_axi_wvalid) begin
                  if (w_cnt != WAIT_C)
                     w_cnt <= w_cnt + 4'd1;
               end else begin
                  w_cnt <= 4'd0;
               end

               if ((aw_got || aw_hs) && (w_got || w_hs))
                  wr_state <= W_COMMIT;
            end
            W_COMMIT: begin
               aw_got       <= 1'b0;
               w_got        <= 1'b0;
               s_axi_bvalid <= 1'b1;
               s_axi_bresp  <= wr_resp;
               wr_state     <= W_RESP;
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid <= 1'b0;
                  s_axi_bresp  <= RESP_OKAY;
                  wr_state     <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // ---- read FSM ----
   always_ff @(posedge clk) begin
      if (!m_aresetn) begin
         rd_state     <= R_IDLE;
         ar_cnt       <= 4'd0;
         s_axi_rvalid <= 1'b0;
         s_axi_rresp  <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  ar_cnt       <= 4'd0;
                  s_axi_rvalid <= 1'b1;
                  s_axi_rresp  <= rd_resp;
                  rd_state     <= R_RESP;
               end else if (s_axi_arvalid) begin
                  if (ar_cnt != WAIT_C)
                     ar_cnt <= ar_cnt + 4'd1;
               end else begin
                  ar_cnt <= 4'd0;
               end
            end
            R_RESP: begin
               if (s_axi_rready) begin
                  s_axi_rvalid <= 1'b0;
                  s_axi_rresp  <= RESP_OKAY;
                  rd_state     <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   // ---- storage ----
   // mem_q only loads on the AR handshake, so it holds through R_RESP
   // even if a write commits to the same word meanwhile.
   axi_sram_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (awaddr_q[AW+1:2]),
      .wdata (wdata_q),
      .wstrb (wstrb_q),
      .re    (ar_hs),
      .raddr (s_axi_araddr[AW+1:2]),
      .rdata (mem_q)
   );

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Bench for axi_lite_sram_slave: instance 0 has WAIT_CYCLES=0, instance 1
// has WAIT_CYCLES=2. A word-array reference model tracks instance 0.
module tb_axi_lite_sram_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        m_aresetn;
   logic [31:0] awaddr  [2];
   logic [2:0]  awsize  [2];
   logic        awvalid [2];
   logic        awready [2];
   logic [31:0] wdata   [2];
   logic [3:0]  wstrb   [2];
   logic        wvalid  [2];
   logic        wready  [2];
   logic [1:0]  bresp   [2];
   logic        bvalid  [2];
   logic        bready  [2];
   logic [31:0] araddr  [2];
   logic [2:0]  arsize  [2];
   logic        arvalid [2];
   logic        arready [2];
   logic [31:0] rdata   [2];
   logic [1:0]  rresp   [2];
   logic        rvalid  [2];
   logic        rready  [2];

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [256];

   axi_lite_sram_slave #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .m_aresetn(m_aresetn),
      .s_axi_awaddr(awaddr[0]), .s_axi_awsize(awsize[0]),
      .s_axi_awvalid(awvalid[0]), .s_axi_awready(awready[0]),
      .s_axi_wdata(wdata[0]), .s_axi_wstrb(wstrb[0]),
      .s_axi_wvalid(wvalid[0]), .s_axi_wready(wready[0]),
      .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready[0]),
      .s_axi_araddr(araddr[0]), .s_axi_arsize(arsize[0]),
      .s_axi_arvalid(arvalid[0]), .s_axi_arready(arready[0]),
      .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]),
      .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready[0])
   );

   axi_lite_sram_slave #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .m_aresetn(m_aresetn),
      .s_axi_awaddr(awaddr[1]), .s_axi_awsize(awsize[1]),
      .s_axi_awvalid(awvalid[1]), .s_axi_awready(awready[1]),
      .s_axi_wdata(wdata[1]), .s_axi_wstrb(wstrb[1]),
      .s_axi_wvalid(wvalid[1]), .s_axi_wready(wready[1]),
      .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready[1]),
      .s_axi_araddr(araddr[1]), .s_axi_arsize(arsize[1]),
      .s_axi_arvalid(arvalid[1]), .s_axi_arready(arready[1]),
      .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]),
      .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready[1])
   );

   // ---- reference model ----
   function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] sz);
      if ((a / 4) >= 256) return 2'b11;
      if (sz > 3'd2) return 2'b10;
      if ((sz == 3'd1) && (a % 2 != 0)) return 2'b10;
      if ((sz == 3'd2) && (a % 4 != 0)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] dat, input logic [3:0] st);
      int idx;
      if (exp_resp(a, sz) == 2'b00) begin
         idx = int'(a >> 2);
         for (int b = 0; b < 4; b++)
            if (st[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] sz);
      if (exp_resp(a, sz) != 2'b00) return 32'h0;
      return ref_mem[int'(a >> 2)];
   endfunction

   // ---- transaction drivers ----
   task automatic do_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] dat, input logic [3:0] st,
                           output logic [1:0] resp, output int lat);
      bit aw_done, w_done;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      awaddr[d] = a; awsize[d] = sz; wdata[d] = dat; wstrb[d] = st;
      awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = 1'b0;
      while (!(aw_done && w_done) && n < 40) begin
         @(negedge clk);
         if (awvalid[d] && awready[d]) aw_done = 1;
         if (wvalid[d] && wready[d]) w_done = 1;
         @(posedge clk); #1;
         if (aw_done) awvalid[d] = 1'b0;
         if (w_done) wvalid[d] = 1'b0;
         n++;
      end
      awvalid[d] = 1'b0; wvalid[d] = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (bvalid[d]) break;
      end
      resp = bresp[d];
      if (bvalid[d] !== 1'b1) begin
         checks++; errors++;
         $display("FAIL write_timeout dut%0d addr=%h: bvalid=%b, required 1", d, a, bvalid[d]);
      end
      bready[d] = 1'b1;
      @(posedge clk); #1;
      bready[d] = 1'b0;
   endtask

   task automatic do_read(input int d, input logic [31:0] a, input logic [2:0] sz,
                          output logic [31:0] dat, output logic [1:0] resp, output int lat);
      bit hs;
      int n;
      hs = 0; n = 0;
      araddr[d] = a; arsize[d] = sz; arvalid[d] = 1'b1; rready[d] = 1'b0;
      while (!hs && n < 40) begin
         @(negedge clk);
         if (arready[d]) hs = 1;
         @(posedge clk); #1;
         if (hs) arvalid[d] = 1'b0;
         n++;
      end
      arvalid[d] = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (rvalid[d]) break;
      end
      dat = rdata[d]; resp = rresp[d];
      if (rvalid[d] !== 1'b1) begin
         checks++; errors++;
         $display("FAIL read_timeout dut%0d addr=%h: rvalid=%b, required 1", d, a, rvalid[d]);
      end
      rready[d] = 1'b1;
      @(posedge clk); #1;
      rready[d] = 1'b0;
   endtask

   // ---- tests ----
   task automatic test_reset();
      m_aresetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({awready[d], wready[d], arready[d], bvalid[d], rvalid[d]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl dut%0d: aw/w/ar ready,bvalid,rvalid=%b, required 00000", d,
                     {awready[d], wready[d], arready[d], bvalid[d], rvalid[d]});
         end
         checks++;
         if ({bresp[d], rresp[d], rdata[d]} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data dut%0d: bresp=%b rresp=%b rdata=%h, required 0", d,
                     bresp[d], rresp[d], rdata[d]);
         end
      end
      @(posedge clk); #1;
      m_aresetn = 1'b1;
   endtask

   task automatic test_word_write();
      logic [1:0] resp; logic [31:0] dat; int lat;
      do_write(0, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF, resp, lat);
      model_write(32'h10, 3'd2, 32'hDEADBEEF, 4'hF);
      checks++;
      if (resp !== 2'b00) begin
         errors++; $display("FAIL word_write_bresp: got %b, required 00", resp);
      end
      checks++;
      if (lat !== 2) begin
         errors++; $display("FAIL word_write_blat: bvalid after %0d cycles, required 2", lat);
      end
      do_read(0, 32'h10, 3'd2, dat, resp, lat);
      checks++;
      if (dat !== 32'hDEADBEEF || resp !== 2'b00) begin
         errors++; $display("FAIL word_read: rdata=%h rresp=%b, required deadbeef 00", dat, resp);
      end
      checks++;
      if (lat !== 1) begin
         errors++; $display("FAIL word_read_lat: rvalid after %0d cycles, required 1", lat);
      end
   endtask

   task automatic test_byte_write();
      logic [1:0] resp; logic [31:0] dat; int lat;
      do_write(0, 32'h13, 3'd0, 32'hA500_0000, 4'b1000, resp, lat);
      model_write(32'h13, 3'd0, 32'hA500_0000, 4'b1000);
      checks++;
      if (resp !== 2'b00) begin
         errors++; $display("FAIL byte_write_bresp: got %b, required 00", resp);
      end
      do_read(0, 32'h10, 3'd2, dat, resp, lat);
      checks++;
      if (dat !== 32'hA5ADBEEF || dat !== model_read(32'h10, 3'd2)) begin
         errors++; $display("FAIL byte_write_read: rdata=%h, required a5adbeef", dat);
      end
   endtask

   task automatic test_w_before_aw();
      int wc, ac, wk, ak;
      bit whs, ahs;
      logic [31:0] dat; logic [1:0] resp; int lat;
      wc = 0; ac = 0; wk = -1; ak = -1;
      awaddr[1] = 32'h20; awsize[1] = 3'd2; wdata[1] = 32'hCAFEF00D; wstrb[1] = 4'hF;
      bready[1] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (k == 0) wvalid[1] = 1'b1;
         if (k == 3) awvalid[1] = 1'b1;
         @(negedge clk);
         whs = wvalid[1] && wready[1];
         ahs = awvalid[1] && awready[1];
         if (wready[1]) begin wc++; wk = k; end
         if (awready[1]) begin ac++; ak = k; end
         @(posedge clk); #1;
         if (whs) wvalid[1] = 1'b0;
         if (ahs) awvalid[1] = 1'b0;
      end
      awvalid[1] = 1'b0; wvalid[1] = 1'b0;
      checks++;
      if (wc !== 1 || wk !== 2) begin
         errors++; $display("FAIL w_first_wready: %0d pulses last at cycle %0d, required 1 at 2", wc, wk);
      end
      checks++;
      if (ac !== 1 || ak !== 5) begin
         errors++; $display("FAIL w_first_awready: %0d pulses last at cycle %0d, required 1 at 5", ac, ak);
      end
      @(negedge clk);
      checks++;
      if (bvalid[1] !== 1'b1 || bresp[1] !== 2'b00) begin
         errors++; $display("FAIL w_first_bresp: bvalid=%b bresp=%b, required 1 00", bvalid[1], bresp[1]);
      end
      bready[1] = 1'b1;
      @(posedge clk); #1;
      bready[1] = 1'b0;
      do_read(1, 32'h20, 3'd2, dat, resp, lat);
      checks++;
      if (dat !== 32'hCAFEF00D || resp !== 2'b00) begin
         errors++; $display("FAIL w_first_read: rdata=%h rresp=%b, required cafef00d 00", dat, resp);
      end
   endtask

   task automatic test_errors();
      logic [1:0] resp; logic [31:0] dat; int lat;
      do_read(0, 32'h400, 3'd2, dat, resp, lat);
      checks++;
      if (resp !== 2'b11 || dat !== 32'h0) begin
         errors++; $display("FAIL err_read_range: rresp=%b rdata=%h, required 11 0", resp, dat);
      end
      do_write(0, 32'h401, 3'd2, 32'h0BADF00D, 4'hF, resp, lat);
      checks++;
      if (resp !== 2'b11) begin
         errors++; $display("FAIL err_write_range: bresp=%b, required 11", resp);
      end
      do_write(0, 32'h4, 3'd2, 32'h12345678, 4'hF, resp, lat);
      model_write(32'h4, 3'd2, 32'h12345678, 4'hF);
      do_write(0, 32'h6, 3'd2, 32'hFFFFFFFF, 4'hF, resp, lat);
      checks++;
      if (resp !== 2'b10) begin
         errors++; $display("FAIL err_write_align: bresp=%b, required 10", resp);
      end
      do_read(0, 32'h4, 3'd2, dat, resp, lat);
      checks++;
      if (dat !== 32'h12345678) begin
         errors++; $display("FAIL err_word1_kept: rdata=%h, required 12345678", dat);
      end
   endtask

   task automatic test_random();
      logic [1:0] resp; logic [31:0] dat, a, v; logic [2:0] sz; logic [3:0] st; int lat;
      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         do_write(0, 32'(i * 4), 3'd2, v, 4'hF, resp, lat);
         model_write(32'(i * 4), 3'd2, v, 4'hF);
      end
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 63));
         else a = 32'($urandom_range(0, 63));
         sz = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            v = $urandom; st = 4'($urandom);
            do_write(0, a, sz, v, st, resp, lat);
            model_write(a, sz, v, st);
            checks++;
            if (resp !== exp_resp(a, sz)) begin
               errors++; $display("FAIL rand_write a=%h sz=%0d: bresp=%b, required %b", a, sz, resp, exp_resp(a, sz));
            end
         end else begin
            do_read(0, a, sz, dat, resp, lat);
            checks++;
            if (resp !== exp_resp(a, sz) || dat !== model_read(a, sz)) begin
               errors++; $display("FAIL rand_read a=%h sz=%0d: rresp=%b rdata=%h, required %b %h",
                                  a, sz, resp, dat, exp_resp(a, sz), model_read(a, sz));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit hs; int n; logic [31:0] exp; logic [1:0] resp; int lat;
      // read side: hold rready low with a second AR pending
      exp = model_read(32'h10, 3'd2);
      araddr[0] = 32'h10; arsize[0] = 3'd2; arvalid[0] = 1'b1; rready[0] = 1'b0;
      hs = 0; n = 0;
      while (!hs && n < 40) begin
         @(negedge clk);
         if (arready[0]) hs = 1;
         @(posedge clk); #1;
         n++;
      end
      araddr[0] = 32'h14;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (rvalid[0] !== 1'b1 || rdata[0] !== exp || rresp[0] !== 2'b00) begin
            errors++; $display("FAIL bp_r_hold cyc%0d: rvalid=%b rdata=%h, required 1 %h", k, rvalid[0], rdata[0], exp);
         end
         checks++;
         if (arready[0] !== 1'b0) begin
            errors++; $display("FAIL bp_ar_block cyc%0d: arready=%b, required 0", k, arready[0]);
         end
         @(posedge clk); #1;
      end
      rready[0] = 1'b1;
      @(posedge clk); #1;
      rready[0] = 1'b0;
      hs = 0; n = 0;
      while (!hs && n < 40) begin
         @(negedge clk);
         if (arready[0]) hs = 1;
         @(posedge clk); #1;
         n++;
      end
      arvalid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== model_read(32'h14, 3'd2)) begin
         errors++; $display("FAIL bp_second_read: rvalid=%b rdata=%h, required 1 %h", rvalid[0], rdata[0], model_read(32'h14, 3'd2));
      end
      rready[0] = 1'b1;
      @(posedge clk); #1;
      rready[0] = 1'b0;
      // write side: bready low holds bvalid/bresp
      awaddr[0] = 32'h9; awsize[0] = 3'd2; wdata[0] = 32'h55; wstrb[0] = 4'hF;
      awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b0;
      @(posedge clk); #1;
      awvalid[0] = 1'b0; wvalid[0] = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (bvalid[0] !== 1'b1 || bresp[0] !== 2'b10) begin
            errors++; $display("FAIL bp_b_hold cyc%0d: bvalid=%b bresp=%b, required 1 10", k, bvalid[0], bresp[0]);
         end
         @(posedge clk); #1;
      end
      bready[0] = 1'b1;
      @(posedge clk); #1;
      bready[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (bvalid[0] !== 1'b0) begin
         errors++; $display("FAIL bp_b_release: bvalid=%b, required 0", bvalid[0]);
      end
      resp = 2'b00; lat = 0;
   endtask

   task automatic test_reset_mid_write();
      logic [1:0] resp; logic [31:0] dat; int lat;
      bit hs; int n;
      do_write(0, 32'h20, 3'd2, 32'h11111111, 4'hF, resp, lat);
      model_write(32'h20, 3'd2, 32'h11111111, 4'hF);
      awaddr[0] = 32'h20; awsize[0] = 3'd2; wdata[0] = 32'h22222222; wstrb[0] = 4'hF;
      awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b0;
      hs = 0; n = 0;
      while (!hs && n < 40) begin
         @(negedge clk);
         if (awready[0] && wready[0]) hs = 1;
         @(posedge clk); #1;
         n++;
      end
      // now in W_COMMIT: reset takes effect on the commit edge
      awvalid[0] = 1'b0; wvalid[0] = 1'b0;
      m_aresetn = 1'b0;
      @(negedge clk);
      checks++;
      if ({awready[0], wready[0], arready[0], bvalid[0], rvalid[0], bresp[0], rresp[0], rdata[0]} !== 41'h0) begin
         errors++; $display("FAIL midwr_outputs: bvalid=%b bresp=%b rvalid=%b rdata=%h, required all 0",
                            bvalid[0], bresp[0], rvalid[0], rdata[0]);
      end
      @(posedge clk); #1;
      m_aresetn = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bvalid[0] !== 1'b0) begin
         errors++; $display("FAIL midwr_no_bresp: bvalid=%b, required 0", bvalid[0]);
      end
      @(posedge clk); #1;
      do_read(0, 32'h20, 3'd2, dat, resp, lat);
      checks++;
      if (dat !== 32'h11111111 || dat !== model_read(32'h20, 3'd2)) begin
         errors++; $display("FAIL midwr_ram_kept: rdata=%h, required 11111111", dat);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         awaddr[d] = '0; awsize[d] = '0; awvalid[d] = 1'b0;
         wdata[d] = '0; wstrb[d] = '0; wvalid[d] = 1'b0; bready[d] = 1'b0;
         araddr[d] = '0; arsize[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      m_aresetn = 1'b0;
      test_reset();
      test_word_write();
      test_byte_write();
      test_w_before_aw();
      test_errors();
      test_random();
      test_backpressure();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
